pc_unit: RTL and testbench

//  Parametrised fetch-PC generator: next generation of the pipeline PC register.

---
 rtl/pc_unit.sv | 119 +++++++++++
 tb/tb_pc_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-PC generator with imem handshake and a DEPTH-entry return-address stack.
// Optional build macro: MISALIGN_CHECK_EN traps misaligned flush targets to EXC_VEC.
module pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h5c,
  parameter logic [XLEN-1:0] EXC_VEC  = 'h04,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pause,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            exc,
  input  logic            imem_ready,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign_fault
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic [PW-1:0]   ptr_q, ptr_d, top_idx, wr_idx;
  logic [PW:0]     cnt_q, cnt_d;
  logic            wr_en;
  logic [XLEN-1:0] mem [DEPTH];
  logic            advance;

  assign pc        = pc_q;
  assign pc_valid  = valid_q;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == (PW+1)'(DEPTH));
  assign top_idx   = ptr_q - 1'b1;
  assign advance   = valid_q & ~pause & imem_ready;

`ifdef MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign misalign_fault = fault_q;
`else
  assign misalign_fault = 1'b0;
`endif

  always_comb begin
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
`ifdef MISALIGN_CHECK_EN
    fault_d = 1'b0;
`endif
    if (exc) begin
      pc_d  = EXC_VEC;
      cnt_d = '0;
    end else if (flush) begin
      pc_d = flush_pc;
`ifdef MISALIGN_CHECK_EN
      if (flush_pc[1:0] != 2'b00) begin
        pc_d    = EXC_VEC;
        fault_d = 1'b1;
      end
`endif
    end else if (advance) begin
      if (ras_pop && !ras_empty) begin
        pc_d = mem[top_idx];
        // push+pop swaps the top in place, so depth and pointer stay put
        if (ras_push) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          ptr_d = top_idx;
          cnt_d = cnt_q - 1'b1;
        end
      end else begin
        pc_d = pc_plus4;
        if (ras_push) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
          if (!ras_full) cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef MISALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Entries are only readable below cnt_q, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= ras_push_addr;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic against a queue-based model.
module tb_pc_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h5c;
  localparam logic [31:0] EXC_VEC  = 32'h04;

  logic        clk, rst, pause, flush, exc, imem_ready, ras_push, ras_pop;
  logic [31:0] flush_pc, ras_push_addr;
  logic [31:0] pc, pc_plus4;
  logic        pc_valid, ras_empty, ras_full, misalign_fault;

  pc_unit #(.XLEN(32), .RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush), .flush_pc(flush_pc),
    .exc(exc), .imem_ready(imem_ready), .ras_push(ras_push),
    .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .pc(pc), .pc_plus4(pc_plus4),
    .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full),
    .misalign_fault(misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model: PC value plus a plain queue of return addresses (back = top)
  logic [31:0] m_pc;
  logic        m_valid, m_fault;
  logic [31:0] ras [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("pc_valid", 32'(pc_valid), 32'(m_valid));
    chk("ras_empty", 32'(ras_empty), 32'(ras.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(ras.size() == DEPTH));
    chk("misalign_fault", 32'(misalign_fault), 32'(m_fault));
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 1'b0; m_fault = 1'b0; ras.delete();
  endtask

  task automatic model_edge();
    bit adv;
    adv = m_valid && !pause && imem_ready;
    m_fault = 1'b0;
    if (exc) begin
      m_pc = EXC_VEC; ras.delete();
    end else if (flush) begin
`ifdef MISALIGN_CHECK_EN
      if (flush_pc[1:0] != 2'b00) begin m_pc = EXC_VEC; m_fault = 1'b1; end
      else m_pc = flush_pc;
`else
      m_pc = flush_pc;
`endif
    end else if (adv) begin
      if (ras_pop && ras.size() > 0) begin
        m_pc = ras[$];
        if (ras_push) ras[ras.size()-1] = ras_push_addr;
        else void'(ras.pop_back());
      end else begin
        m_pc = m_pc + 32'd4;
        if (ras_push) begin
          if (ras.size() == DEPTH) void'(ras.pop_front());
          ras.push_back(ras_push_addr);
        end
      end
    end
    m_valid = 1'b1;
  endtask

  task automatic idle();
    pause = 0; flush = 0; flush_pc = '0; exc = 0; imem_ready = 1;
    ras_push = 0; ras_push_addr = '0; ras_pop = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    idle();
  endtask

  task automatic do_flush(input logic [31:0] a);
    flush = 1; flush_pc = a; cycle();
  endtask

  task automatic push(input logic [31:0] a);
    ras_push = 1; ras_push_addr = a; cycle();
  endtask

  task automatic pop();
    ras_pop = 1; cycle();
  endtask

  initial begin
    idle();
    rst = 0;
    model_reset();
    #12;
    chk("reset_pc", pc, RESET_PC);
    chk("reset_valid", 32'(pc_valid), 32'd0);
    check_all();
    @(posedge clk); #1;
    rst = 1;

    // 1: reset release sequence
    chk("t1_pre_pc", pc, 32'h5c);
    chk("t1_pre_valid", 32'(pc_valid), 32'd0);
    cycle(); chk("t1_c1_pc", pc, 32'h5c); chk("t1_c1_valid", 32'(pc_valid), 32'd1);
    cycle(); chk("t1_c2_pc", pc, 32'h60);
    cycle(); chk("t1_c3_pc", pc, 32'h64);

    // 2: pause holds, flush overrides pause
    do_flush(32'h80);
    for (int i = 0; i < 3; i++) begin
      pause = 1; cycle(); chk("t2_hold", pc, 32'h80);
    end
    pause = 1; flush = 1; flush_pc = 32'h200; cycle();
    chk("t2_flush", pc, 32'h200);

    // 3: push three, pop four
    push(32'h100); push(32'h200); push(32'h300);
    do_flush(32'h400);
    pop(); chk("t3_pop1", pc, 32'h300);
    pop(); chk("t3_pop2", pc, 32'h200);
    pop(); chk("t3_pop3", pc, 32'h100);
    pop(); chk("t3_pop4", pc, 32'h104); chk("t3_empty", 32'(ras_empty), 32'd1);

    // 4: overflow overwrites the oldest entry
    for (int i = 1; i <= 5; i++) begin
      push(32'h1000 * i);
      if (i == 4) chk("t4_full", 32'(ras_full), 32'd1);
    end
    for (int i = 5; i >= 2; i--) begin
      pop(); chk("t4_pop", pc, 32'h1000 * i);
    end
    chk("t4_empty", 32'(ras_empty), 32'd1);

    // 5: exc beats flush and clears the RAS; async reset mid-cycle
    push(32'hA0); push(32'hB0);
    exc = 1; flush = 1; flush_pc = 32'h300; cycle();
    chk("t5_exc_pc", pc, EXC_VEC); chk("t5_exc_empty", 32'(ras_empty), 32'd1);
    push(32'hC0); cycle();
    #2 rst = 0; #1;
    model_reset();
    chk("t5_async_pc", pc, 32'h5c);
    chk("t5_async_valid", 32'(pc_valid), 32'd0);
    check_all();
    #1 rst = 1;
    cycle(); cycle();

    // 6: misaligned flush target
    do_flush(32'h202);
`ifdef MISALIGN_CHECK_EN
    chk("t6_pc", pc, EXC_VEC); chk("t6_fault", 32'(misalign_fault), 32'd1);
    cycle(); chk("t6_fault_clr", 32'(misalign_fault), 32'd0);
`else
    chk("t6_pc", pc, 32'h202); chk("t6_fault", 32'(misalign_fault), 32'd0);
    cycle();
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      pause = ($urandom_range(0, 4) == 0);
      imem_ready = ($urandom_range(0, 5) != 0);
      exc = ($urandom_range(0, 30) == 0);
      flush = ($urandom_range(0, 10) == 0);
      flush_pc = $urandom;
      if ($urandom_range(0, 3) != 0) flush_pc[1:0] = 2'b00;
      ras_push = ($urandom_range(0, 2) == 0);
      ras_push_addr = $urandom & 32'hFFFF_FFFC;
      ras_pop = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
